// File: rtl/adc_pulse_gen.sv
// Synthetic detector-pulse source: baseline plus pulses with a linear rise and an
// exponential tail, with pile-up onto the residual tail of earlier pulses.
module adc_pulse_gen #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned AMP_W      = 12,
    parameter int unsigned FRAC       = 8,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned TAU_SHIFT  = 4,
    parameter int unsigned RISE_SHIFT = 2,
    parameter int unsigned BASELINE   = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig_valid,
    input  logic [AMP_W-1:0]  trig_amp,
    output logic              trig_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int unsigned RISE_LEN = 1 << RISE_SHIFT;
    localparam int unsigned CNT_W    = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
    localparam int unsigned INT_W    = ACC_W - FRAC;

    typedef enum logic [1:0] {StIdle, StRise, StDecay} state_e;

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0]  rise_cnt_q, rise_cnt_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              rise_last;
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  acc_sat;
    logic [ACC_W-1:0]  acc_decayed;
    logic [ACC_W-1:0]  amp_ext;
    logic [INT_W:0]    out_sum;

    assign trig_ready = (state_q != StRise);
    assign accept     = trig_valid & trig_ready;
    assign rise_last  = (rise_cnt_q == CNT_W'(RISE_LEN - 1));

    assign amp_ext     = {{(ACC_W - AMP_W){1'b0}}, trig_amp};
    assign acc_sum     = {1'b0, acc_q} + {1'b0, step_q};
    assign acc_sat     = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    assign acc_decayed = acc_q - (acc_q >> TAU_SHIFT);
    assign out_sum     = (INT_W + 1)'(BASELINE) + {1'b0, acc_q[ACC_W-1:FRAC]};

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        step_d     = step_q;
        rise_cnt_d = rise_cnt_q;

        // Accept wins over decay in DECAY: the new pulse stacks on the residual tail.
        if (accept) begin
            step_d     = (amp_ext << FRAC) >> RISE_SHIFT;
            rise_cnt_d = '0;
            state_d    = StRise;
        end else begin
            unique case (state_q)
                StRise: begin
                    acc_d      = acc_sat;
                    rise_cnt_d = rise_cnt_q + CNT_W'(1);
                    if (rise_last) begin
                        state_d = StDecay;
                    end
                end
                StDecay: begin
                    acc_d = acc_decayed;
                    if ((acc_decayed >> FRAC) == '0) begin
                        acc_d   = '0;
                        state_d = StIdle;
                    end
                end
                default: acc_d = '0;
            endcase
        end

        out_d  = (out_sum > (INT_W + 1)'((1 << DATA_W) - 1)) ? {DATA_W{1'b1}}
                                                              : out_sum[DATA_W-1:0];
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            step_q     <= '0;
            rise_cnt_q <= '0;
            out_q      <= DATA_W'(BASELINE);
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
            rise_cnt_q <= rise_cnt_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
        end
    end

    assign out_data = out_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_adc_pulse_gen.sv
// Bench for adc_pulse_gen: directed pulse scenarios with literal expectations plus a
// randomized run, all checked every cycle against a pulse-level behavioural model.
module tb_adc_pulse_gen;

    localparam longint BASE    = 100;
    localparam longint OUT_MAX = 4095;
    localparam longint ACC_MAX = (64'd1 << 24) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        trig_valid;
    logic [11:0] trig_amp;
    logic        trig_ready;
    logic [11:0] out_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Model state: accumulator in 1/256 counts, rise cycles still to add, pulse alive.
    longint m_acc, m_step, m_out;
    int     m_rise;
    bit     m_live;
    bit     m_ok = 1'b0;

    adc_pulse_gen dut (
        .clk        (clk),
        .reset      (reset),
        .trig_valid (trig_valid),
        .trig_amp   (trig_amp),
        .trig_ready (trig_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    int sp_out[8];
    int sp_rdy[8];
    int n;

    initial begin
        reset      = 1'b1;
        trig_valid = 1'b0;
        trig_amp   = '0;
        sp_out = '{100, 100, 500, 900, 1300, 1700, 1600, 1506};
        sp_rdy = '{0, 0, 0, 0, 1, 1, 1, 1};

        fork
            forever begin
                @(posedge clk);
                if (reset) begin
                    m_acc = 0; m_step = 0; m_rise = 0; m_live = 0; m_out = BASE; m_ok = 1;
                end else if (m_ok) begin
                    m_out = BASE + m_acc / 256;
                    if (m_out > OUT_MAX) m_out = OUT_MAX;
                    if (trig_valid && m_rise == 0) begin
                        m_step = longint'(trig_amp) * 256 / 4;
                        m_rise = 4;
                        m_live = 1;
                    end else if (m_rise > 0) begin
                        m_acc = m_acc + m_step;
                        if (m_acc > ACC_MAX) m_acc = ACC_MAX;
                        m_rise--;
                    end else if (m_live) begin
                        m_acc = m_acc - m_acc / 16;
                        if (m_acc / 256 == 0) begin
                            m_acc  = 0;
                            m_live = 0;
                        end
                    end
                end
            end
            forever begin
                @(negedge clk);
                if (m_ok) begin
                    check("cyc_out", {20'd0, out_data}, m_out[31:0]);
                    check("cyc_busy", {31'd0, busy}, {31'd0, m_live});
                    check("cyc_ready", {31'd0, trig_ready}, {31'd0, m_rise == 0});
                end
            end
        join_none

        // Reset and idle
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        check("idle_out", {20'd0, out_data}, 32'd100);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_ready", {31'd0, trig_ready}, 32'd1);

        // Single pulse, amp 1600
        trig_amp = 12'd1600; trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("sp_out", {20'd0, out_data}, sp_out[i]);
            check("sp_ready", {31'd0, trig_ready}, sp_rdy[i]);
            check("sp_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        wait_idle(500);
        repeat (3) tick();

        // Smallest pulse decays straight to idle
        trig_amp = 12'd1; trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        repeat (4) tick();
        check("amp1_pre_out", {20'd0, out_data}, 32'd100);
        check("amp1_pre_busy", {31'd0, busy}, 32'd1);
        tick();
        check("amp1_peak", {20'd0, out_data}, 32'd101);
        check("amp1_idle", {31'd0, busy}, 32'd0);
        tick();
        check("amp1_back", {20'd0, out_data}, 32'd100);
        repeat (3) tick();

        // Pile-up on second decay cycle
        trig_amp = 12'd1600; trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        repeat (5) tick();
        trig_amp = 12'd1000; trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        check("pile_accept_out", {20'd0, out_data}, 32'd1600);
        check("pile_ready", {31'd0, trig_ready}, 32'd0);
        repeat (4) tick();
        check("pile_rise_out", {20'd0, out_data}, 32'd2350);
        tick();
        check("pile_peak", {20'd0, out_data}, 32'd2600);
        tick();
        check("pile_decay", {20'd0, out_data}, 32'd2443);
        wait_idle(500);
        repeat (3) tick();

        // Saturation of the output
        trig_amp = 12'd4095; trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        repeat (4) tick();
        trig_valid = 1'b1;
        tick();
        trig_valid = 1'b0;
        check("sat_first", {20'd0, out_data}, 32'd4095);
        repeat (5) tick();
        check("sat_peak", {20'd0, out_data}, 32'd4095);
        check("sat_busy", {31'd0, busy}, 32'd1);
        wait_idle(500);
        repeat (3) tick();

        // Trigger held during RISE is ignored, then reset mid-decay
        trig_amp = 12'd1600; trig_valid = 1'b1;
        tick();
        repeat (3) tick();
        trig_valid = 1'b0;
        repeat (2) tick();
        check("ign_peak", {20'd0, out_data}, 32'd1700);
        tick();
        check("ign_next", {20'd0, out_data}, 32'd1600);
        check("ign_ready", {31'd0, trig_ready}, 32'd1);
        n = 0;
        while (out_data > 12'd1200 && n < 200) begin
            tick();
            n++;
        end
        check("rst_reach_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        check("rst_out", {20'd0, out_data}, 32'd100);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, trig_ready}, 32'd1);
        reset = 1'b0;
        repeat (3) tick();

        // Randomized triggers, amplitudes and occasional resets
        for (int c = 0; c < 4000; c++) begin
            reset      = ($urandom_range(0, 499) == 0);
            trig_valid = ($urandom_range(0, 7) == 0);
            trig_amp   = ($urandom_range(0, 3) == 0) ? 12'(4095 - $urandom_range(0, 63))
                                                     : 12'($urandom_range(0, 4095));
            tick();
        end
        reset      = 1'b0;
        trig_valid = 1'b0;
        wait_idle(500);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_pulse_gen.md
Name: adc_pulse_gen

Overview:
- Synthetic detector-pulse source. Produces an ADC-format sample stream: a baseline plus pulses with a linear leading edge and an exponential tail, with pile-up of overlapping pulses.
- Drives the input of the trapezoidal shaping filters in place of the real ADC, for bench and on-board self-test.
- Each pulse is started by a trigger/amplitude handshake from a test sequencer or CPU register block.

Parameters:
- DATA_W, 12, width of out_data. Matches the ADC sample width.
- AMP_W, 12, width of trig_amp.
- FRAC, 8, fractional bits in the internal accumulator.
- ACC_W, 24, accumulator width. Must equal AMP_W+FRAC+4.
- TAU_SHIFT, 4, decay per sample is acc>>TAU_SHIFT, giving tau ≈ 2^TAU_SHIFT samples.
- RISE_SHIFT, 2, rise length RISE_LEN = 2^RISE_SHIFT samples.
- BASELINE, 100, constant pedestal added to every output sample.

Ports:
- clk, input, 1, sample clock. One output sample per cycle.
- reset, input, 1, synchronous reset, active-high.
- trig_valid, input, 1, pulse request.
- trig_amp, input, AMP_W, pulse amplitude in ADC counts, unsigned.
- trig_ready, output, 1, request can be accepted this cycle.
- out_data, output, DATA_W, synthesized sample, unsigned.
- busy, output, 1, accumulator is non-zero (state != IDLE).

Behaviour:
- Reset (sync, active-high, overrides everything, including mid-pulse):
  - state=IDLE, acc=0, rise_cnt=0, step=0.
  - out_data=BASELINE, trig_ready=1, busy=0.
  - First cycle after reset deasserts: out_data=BASELINE.
- FSM states: IDLE, RISE, DECAY.
- trig_ready = (state != RISE), combinational from state.
- Accept = trig_valid & trig_ready at a rising edge. On accept:
  - step <= (trig_amp << FRAC) >> RISE_SHIFT.
  - rise_cnt <= 0; state <= RISE.
  - acc is not modified on the accept edge.
- RISE, each cycle:
  - acc <= sat(acc + step), clamped at 2^ACC_W-1.
  - rise_cnt++.
  - When rise_cnt == RISE_LEN-1, state <= DECAY. RISE therefore lasts exactly RISE_LEN cycles.
  - No decay is applied during RISE.
  - trig_valid is ignored (trig_ready=0); there is no queueing.
- DECAY, each cycle:
  - acc <= acc - (acc >> TAU_SHIFT), logical shift.
  - If the post-update integer part (acc_next >> FRAC) == 0, then acc <= 0 and state <= IDLE in the same edge.
  - An accept in DECAY (pile-up) takes priority: that edge goes to RISE with acc unchanged. The new pulse stacks on the residual tail.
- IDLE: acc holds 0.
- Output:
  - out_data <= min(BASELINE + (acc >> FRAC), 2^DATA_W-1), registered from the current acc.
  - out_data lags acc by one cycle.
  - Latency: accept at edge N, first raised sample visible after edge N+2.
- busy: registered, 1 when state != IDLE (i.e. after the accept edge), 0 after the edge entering IDLE.
- Arithmetic: all unsigned. Truncation toward zero in every shift. No wrap anywhere; adds saturate.
- Simultaneous events:
  - reset beats trig_valid.
  - Accept in DECAY beats the decay-to-IDLE exit.

Test Plan:
- Reset/idle: hold reset 3 cycles, release, no trigger for 20 cycles -> out_data=100 every cycle, trig_ready=1, busy=0.
- Single pulse, amp=1600 (step=400·256):
  - out_data after accept = 100, 100, 500, 900, 1300, 1700, 1600, 1506, …
  - busy=1 from the edge after accept; trig_ready=0 for exactly 4 cycles.
- Decay to idle, amp=1:
  - acc=256 after rise, out_data peaks at 101.
  - The first decay gives 240, integer 0 -> IDLE, busy=0, out_data returns to 100.
- Pile-up: amp=1600, then a second trigger amp=1000 on the 2nd DECAY cycle (acc integer 1500) -> rise continues from 1500 to 2500, out_data peak 2600, then decays.
- Saturation: amp=4095, then again at the first DECAY cycle -> out_data clamps at 4095, never wraps; acc stays ≤ 2^24-1.
- Trigger during RISE ignored; reset mid-DECAY:
  - A trig_valid held only during RISE cycles produces no second pulse.
  - Asserting reset at out_data≈1200 -> next sample 100, state IDLE, busy=0.
